// File: rtl/mna_flit_rx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mna_flit_rx_sequencer_pkg
// Shared definitions for the manager network adapter receive sequencer:
// flit type encodings, flit field positions and the sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package mna_flit_rx_sequencer_pkg;

   // Flit type field, bits [36:35] of a NoC flit
   typedef enum logic [1:0] {
      FLIT_TYPE_IDLE   = 2'b00,
      FLIT_TYPE_BODY   = 2'b01,
      FLIT_TYPE_HEAD   = 2'b10,
      FLIT_TYPE_SINGLE = 2'b11
   } flit_type_e;

   // Field positions inside a 37-bit flit
   localparam int FLIT_TYPE_MSB = 36;
   localparam int FLIT_TYPE_LSB = 35;
   localparam int FLIT_WR_BIT   = 34;
   localparam int FLIT_RSVD_MSB = 33;
   localparam int FLIT_RSVD_LSB = 32;
   localparam int PAYLOAD_MSB   = 31;
   localparam int PAYLOAD_LSB   = 0;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_BODY = 2'b01,
      ST_ISSUE     = 2'b10
   } seq_state_e;

endpackage

// File: rtl/mna_flit_rx_sequencer_if.sv
// ---------------------------------------------------------------------------
// mna_flit_rx_sequencer_if
// Bundles the NoC flit input handshake and the AXI-side command handshake.
//   noc_data/noc_valid/noc_ready : incoming flit, accepted on valid && ready
//   cmd_valid/cmd_ready          : command handshake towards the AXI master
//   cmd_write/cmd_addr/cmd_wdata : command fields
// Modports:
//   master : the sequencer (consumes flits, produces commands)
//   slave  : the surrounding logic (produces flits, consumes commands)
// ---------------------------------------------------------------------------
interface mna_flit_rx_sequencer_if #(
   parameter int FLIT_W = 37,
   parameter int DATA_W = 32
);
   logic [FLIT_W-1:0] noc_data;
   logic              noc_valid;
   logic              noc_ready;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [DATA_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   modport master (
      input  noc_data, noc_valid, cmd_ready,
      output noc_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata
   );

   modport slave (
      output noc_data, noc_valid, cmd_ready,
      input  noc_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata
   );
endinterface

// File: rtl/mna_flit_rx_sequencer_field_split.sv
// ---------------------------------------------------------------------------
// mna_flit_field_split
// Purely combinational flit unboxing: splits a NoC flit into its type,
// write flag and payload. Reserved bits are ignored.
//   flit      in  FLIT_W  raw flit
//   flit_type out 2       decoded flit type
//   wr_flag   out 1       write flag (meaningful on head flits only)
//   payload   out DATA_W  address or write data
// ---------------------------------------------------------------------------
module mna_flit_field_split
   import mna_flit_rx_sequencer_pkg::*;
#(
   parameter int FLIT_W = 37,
   parameter int DATA_W = 32
) (
   input  logic [FLIT_W-1:0] flit,
   output flit_type_e        flit_type,
   output logic              wr_flag,
   output logic [DATA_W-1:0] payload
);
   logic unused_rsvd;

   assign flit_type   = flit_type_e'(flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
   assign wr_flag     = flit[FLIT_WR_BIT];
   assign payload     = flit[PAYLOAD_MSB:PAYLOAD_LSB];
   assign unused_rsvd = ^flit[FLIT_RSVD_MSB:FLIT_RSVD_LSB];
endmodule

// File: rtl/mna_flit_rx_sequencer.sv
// ---------------------------------------------------------------------------
// mna_flit_rx_sequencer
// Receive-side controller of the manager network adapter. Accepts NoC flits,
// pairs write heads with their body flit, and presents one complete AXI4-Lite
// command per packet. Handles orphan bodies, duplicate heads and a body-wait
// timeout as protocol errors.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   bus        ---  master modport: noc_* flit input, cmd_* command output
//   err_pulse  out  one-cycle pulse per protocol error
//   err_count  out  saturating protocol-error count
// ---------------------------------------------------------------------------
module mna_flit_rx_sequencer
   import mna_flit_rx_sequencer_pkg::*;
#(
   parameter int FLIT_W      = 37,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256,
   parameter int CNT_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mna_flit_rx_sequencer_if.master bus,
   output logic                    err_pulse,
   output logic [CNT_W-1:0]        err_count
);
   localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   seq_state_e        state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              cmd_valid_q;
   logic              err_d, err_q;
   logic [CNT_W-1:0]  err_cnt_q;

   flit_type_e        flit_type;
   logic              wr_flag;
   logic [DATA_W-1:0] payload;
   logic              accept;
   logic              timed_out;

   mna_flit_field_split #(
      .FLIT_W (FLIT_W),
      .DATA_W (DATA_W)
   ) u_field_split (
      .flit      (bus.noc_data),
      .flit_type (flit_type),
      .wr_flag   (wr_flag),
      .payload   (payload)
   );

   // Ready is gated by rst_n so that every output reads 0 while reset is held.
   assign bus.noc_ready = rst_n && (state_q != ST_ISSUE);
   assign accept        = bus.noc_valid && bus.noc_ready;

   // A timeout only fires if no head, single or body flit is accepted in the
   // same cycle; idle flits do not rescue the packet.
   assign timed_out = (state_q == ST_WAIT_BODY) && (cnt_q == TO_LAST) &&
                      !(accept && (flit_type != FLIT_TYPE_IDLE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE, ST_WAIT_BODY: begin
            if (state_q == ST_WAIT_BODY) begin
               cnt_d = cnt_q + TO_W'(1);
            end
            if (accept) begin
               case (flit_type)
                  FLIT_TYPE_HEAD, FLIT_TYPE_SINGLE: begin
                     // A new head while waiting abandons the pending packet
                     // and restarts exactly as from IDLE.
                     if (state_q == ST_WAIT_BODY) begin
                        err_d = 1'b1;
                     end
                     addr_d = payload;
                     cnt_d  = '0;
                     if (flit_type == FLIT_TYPE_HEAD && wr_flag) begin
                        write_d = 1'b1;
                        state_d = ST_WAIT_BODY;
                     end else begin
                        write_d = 1'b0;
                        wdata_d = '0;
                        state_d = ST_ISSUE;
                     end
                  end
                  FLIT_TYPE_BODY: begin
                     if (state_q == ST_IDLE) begin
                        err_d = 1'b1;
                     end else begin
                        wdata_d = payload;
                        write_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                     end
                  end
                  FLIT_TYPE_IDLE: begin
                  end
                  default: begin
                  end
               endcase
            end
            if (timed_out) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (bus.cmd_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         cmd_valid_q <= (state_d == ST_ISSUE);
         err_q       <= err_d;
         if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_write = write_q;
   assign bus.cmd_addr  = addr_q;
   assign bus.cmd_wdata = wdata_q;
   assign err_pulse     = err_q;
   assign err_count     = err_cnt_q;
endmodule

// File: doc/mna_flit_rx_sequencer.md
Name: mna_flit_rx_sequencer

Overview:
- Receive-side controller for the manager network adapter (Mna). Accepts 37-bit NoC flits with a valid/ready handshake and classifies them by flit type.
- Pairs head flits (address and command) with body flits (write data) and issues one complete AXI4-Lite command per packet to the downstream AXI master channel logic.
- Owns packet framing, protocol-error recovery and a body-wait timeout.
- The flit-unboxing field split is done in the sub-module named under Decomposition.

Parameters:
- FLIT_W, 37, flit width; fixed by the NoC format.
- DATA_W, 32, payload width (flit[31:0]).
- TIMEOUT_CYC, 256, maximum cycles spent in WAIT_BODY before the packet is abandoned; must be ≥ 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- noc_data  in  37  incoming flit.
- noc_valid  in  1  flit present.
- noc_ready  out  1  flit accepted when noc_valid && noc_ready.
- cmd_valid  out  1  command available to the AXI side.
- cmd_ready  in  1  AXI side accepts the command.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_addr  out  32  transaction address.
- cmd_wdata  out  32  write data; 0 for reads.
- err_pulse  out  1  one-cycle pulse on any protocol error.
- err_count  out  CNT_W  saturating protocol-error count.

Behaviour:
- Flit format:
  - [36:35] type: 10 head, 01 body, 11 single-flit read, 00 idle/invalid.
  - [34] write flag; valid on head only.
  - [33:32] reserved.
  - [31:0] payload.
- Reset values: every output is 0, state = IDLE, timeout counter = 0.
- noc_ready = 1 in IDLE and WAIT_BODY; 0 in ISSUE. Every flit with type 00 is accepted and silently discarded.
- IDLE, on an accepted flit:
  - head with [34]=1: latch addr = payload; go to WAIT_BODY.
  - head with [34]=0: latch addr; cmd_write = 0; go to ISSUE.
  - type 11: same as a read head.
  - body: protocol error; flit dropped; stay in IDLE.
- WAIT_BODY:
  - Counter increments each cycle.
  - Accepted body: latch wdata; go to ISSUE; cmd_write = 1.
  - Accepted head or type 11: error. The new flit replaces the pending one and is processed exactly as it would be from IDLE. The counter is cleared.
  - Counter reaches TIMEOUT_CYC-1 with no body accepted: error; go to IDLE.
  - Body acceptance in the same cycle as timeout: the body wins and no error is raised.
- ISSUE:
  - cmd_valid = 1. cmd_* fields stay stable until cmd_valid && cmd_ready.
  - On handshake: go to IDLE and drop cmd_valid the next cycle.
- Latency: a command's cmd_valid rises on the cycle after its final flit is accepted. Sustained rate is 1 read per 2 cycles and 1 write per 3 cycles; there is no bypass of ISSUE.
- Error reporting:
  - err_pulse is registered and lasts exactly 1 cycle per error event.
  - err_count increments with each pulse and saturates at 2^CNT_W−1. It does not wrap.
- Asynchronous reset while in WAIT_BODY or ISSUE aborts the packet. No command is emitted after rst_n deasserts until a new packet arrives.

Decomposition:
- Shared package/include holds:
  - FLIT_TYPE_HEAD = 2'b10, FLIT_TYPE_BODY = 2'b01, FLIT_TYPE_SINGLE = 2'b11, FLIT_TYPE_IDLE = 2'b00.
  - Field index constants (type msb/lsb, write bit, payload msb/lsb).
  - State encodings IDLE / WAIT_BODY / ISSUE.
- One combinational sub-module, mna_flit_field_split, decodes type, write flag and payload from noc_data.
- The FSM, counters and output registers live in the top module.

Test Plan:
- Write packet:
  - Stimulus: head 37'h1400000010 (type 10, write=1, addr 0x10), then body 37'h08DEADBEEF, cmd_ready=1.
  - Required response: one cycle of cmd_valid with cmd_write=1, addr=0x10, wdata=0xDEADBEEF, no error. noc_ready=0 during ISSUE.
- Read packet with backpressure:
  - Stimulus: head type 10, write=0, addr 0x20; cmd_ready held 0 for 5 cycles.
  - Required response: cmd_valid stays high with stable fields for 5 cycles, handshake on cycle 6, noc_ready low throughout.
- Orphan body:
  - Stimulus: body flit 37'h08FFFFFFFF while in IDLE.
  - Required response: err_pulse for 1 cycle, err_count=1, no cmd_valid.
- Double head:
  - Stimulus: write head addr 0x10, then write head addr 0x30, then body 0x5.
  - Required response: 1 error; the single command carries addr=0x30, wdata=0x5.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4, write head, no body for 4 cycles.
  - Required response: err_pulse, return to IDLE. A late body arriving afterwards raises a second error, giving err_count=2.
- Reset mid-packet:
  - Stimulus: rst_n pulsed low while in WAIT_BODY, then a body flit is sent.
  - Required response: all outputs 0 during reset; the body after reset is treated as an orphan (error) and no command is issued.
